// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - shared address map, LFSR polynomial and decode helpers for the dmem responder
package dmem_mmio_pkg;

  localparam logic [11:0] ADDR_LED      = 12'hFF0;
  localparam logic [11:0] ADDR_BTN_PEND = 12'hFF1;
  localparam logic [11:0] ADDR_TIMER    = 12'hFF2;
  localparam logic [11:0] ADDR_RAND     = 12'hFF3;
  localparam logic [11:0] ADDR_SCORE    = 12'hFF4;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_BTN,
    SEL_TIMER,
    SEL_RAND,
    SEL_SCORE
  } sel_e;

  function automatic sel_e decode(input logic [11:0] addr, input int ram_depth);
    sel_e sel;
    sel = SEL_NONE;
    if (32'(addr) < 32'(ram_depth)) begin
      sel = SEL_RAM;
    end else begin
      case (addr)
        ADDR_LED:      sel = SEL_LED;
        ADDR_BTN_PEND: sel = SEL_BTN;
        ADDR_TIMER:    sel = SEL_TIMER;
        ADDR_RAND:     sel = SEL_RAND;
        ADDR_SCORE:    sel = SEL_SCORE;
        default:       sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

  // Right-shifting Galois step; a nonzero state never maps to zero since POLY[31] is set.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - 2-flop synchronizer with rising-edge pulse per bit
module btn_sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] s3_q, s3_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign pulse = s2_q & ~s3_q;

endmodule

// File: rtl/dmem_mmio_responder.sv
// rtl/dmem_mmio_responder.sv - dmem slave: word RAM plus whack-a-mole I/O register page
module dmem_mmio_responder
  import dmem_mmio_pkg::*;
#(
  parameter int          RAM_DEPTH   = 1024,
  parameter int          NUM_MOLES   = 9,
  parameter int          CLKS_PER_MS = 50000,
  parameter logic [31:0] LFSR_SEED   = 32'h0000_0001
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [11:0]          address_dmem,
  input  logic [31:0]          d_dmem,
  input  logic                 wren_dmem,
  output logic [31:0]          q_dmem,
  input  logic [NUM_MOLES-1:0] buttons_raw,
  output logic [NUM_MOLES-1:0] leds,
  output logic [15:0]          score_out
);

  localparam int          AW        = $clog2(RAM_DEPTH);
  localparam logic [31:0] PRESC_MAX = 32'(CLKS_PER_MS - 1);

  logic [31:0] ram [RAM_DEPTH];

  logic [31:0]          rdata_q, rdata_d;
  logic [NUM_MOLES-1:0] led_q, led_d;
  logic [NUM_MOLES-1:0] pend_q, pend_d;
  logic [31:0]          timer_q, timer_d;
  logic [31:0]          presc_q, presc_d;
  logic [31:0]          lfsr_q, lfsr_d;
  logic [15:0]          score_q, score_d;

  logic [NUM_MOLES-1:0] btn_edge;
  logic [AW-1:0]        ram_idx;
  sel_e                 sel;

  btn_sync_edge #(.WIDTH(NUM_MOLES)) u_btn (
    .clk   (clock),
    .rst   (reset),
    .din   (buttons_raw),
    .pulse (btn_edge)
  );

  assign ram_idx = address_dmem[AW-1:0];

  always_comb begin
    sel     = decode(address_dmem, RAM_DEPTH);
    led_d   = led_q;
    score_d = score_q;
    pend_d  = pend_q | btn_edge;
    lfsr_d  = lfsr_next(lfsr_q);
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      timer_d = timer_q + 32'd1;
    end else begin
      presc_d = presc_q + 32'd1;
      timer_d = timer_q;
    end

    if (wren_dmem) begin
      case (sel)
        SEL_LED:   led_d = d_dmem[NUM_MOLES-1:0];
        // A new edge wins over a same-cycle clear of the same bit.
        SEL_BTN:   pend_d = (pend_q & ~d_dmem[NUM_MOLES-1:0]) | btn_edge;
        SEL_TIMER: begin
          timer_d = d_dmem;
          presc_d = '0;
        end
        SEL_RAND:  lfsr_d = (d_dmem == 32'd0) ? 32'd1 : d_dmem;
        SEL_SCORE: score_d = d_dmem[15:0];
        default:   ;
      endcase
    end

    // Reads see pre-edge state, giving read-before-write on every target.
    case (sel)
      SEL_RAM:   rdata_d = ram[ram_idx];
      SEL_LED:   rdata_d = 32'(led_q);
      SEL_BTN:   rdata_d = 32'(pend_q);
      SEL_TIMER: rdata_d = timer_q;
      SEL_RAND:  rdata_d = lfsr_q;
      SEL_SCORE: rdata_d = 32'(score_q);
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (wren_dmem && sel == SEL_RAM) begin
      ram[ram_idx] <= d_dmem;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      led_q   <= '0;
      pend_q  <= '0;
      timer_q <= '0;
      presc_q <= '0;
      lfsr_q  <= LFSR_SEED;
      score_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      led_q   <= led_d;
      pend_q  <= pend_d;
      timer_q <= timer_d;
      presc_q <= presc_d;
      lfsr_q  <= lfsr_d;
      score_q <= score_d;
    end
  end

  assign q_dmem    = rdata_q;
  assign leds      = led_q;
  assign score_out = score_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb/tb_dmem_mmio_responder.sv - scoreboard bench for dmem_mmio_responder against a behavioural model
module tb_dmem_mmio_responder;

  localparam int CLKS = 4;
  localparam int NM   = 9;

  logic          clock;
  logic          reset;
  logic [11:0]   address_dmem;
  logic [31:0]   d_dmem;
  logic          wren_dmem;
  logic [31:0]   q_dmem;
  logic [NM-1:0] buttons_raw;
  logic [NM-1:0] leds;
  logic [15:0]   score_out;

  dmem_mmio_responder #(
    .RAM_DEPTH   (1024),
    .NUM_MOLES   (NM),
    .CLKS_PER_MS (CLKS),
    .LFSR_SEED   (32'h0000_0001)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .d_dmem       (d_dmem),
    .wren_dmem    (wren_dmem),
    .q_dmem       (q_dmem),
    .buttons_raw  (buttons_raw),
    .leds         (leds),
    .score_out    (score_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic          do_q;
    logic [31:0]   q;
    logic [NM-1:0] leds;
    logic [15:0]   score;
    logic [11:0]   addr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  // Reference model state
  logic [31:0]   mem [int];
  logic [NM-1:0] m_led;
  logic [15:0]   m_score;
  logic [NM-1:0] m_pend;
  logic [31:0]   m_tbase;
  int unsigned   m_tk;
  logic [31:0]   m_lfsr;
  logic [NM-1:0] raw_hist [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_led   = '0;
    m_score = '0;
    m_pend  = '0;
    m_tbase = '0;
    m_tk    = 0;
    m_lfsr  = 32'd1;
    for (int i = 0; i < 3; i++) raw_hist[i] = '0;
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    n = s / 2;
    if (s % 2 == 1) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  // Drive one access at a negedge, record what the coming edge should produce, advance model.
  task automatic cycle(input logic [11:0] a, input logic we, input logic [31:0] d, input logic [NM-1:0] btn);
    exp_t          e;
    logic [NM-1:0] rise;
    address_dmem = a;
    wren_dmem    = we;
    d_dmem       = d;
    buttons_raw  = btn;
    e.do_q = 1'b1;
    e.q    = '0;
    e.addr = a;
    if (a < 12'd1024) begin
      if (mem.exists(int'(a))) e.q = mem[int'(a)];
      else e.do_q = 1'b0;
    end else begin
      case (a)
        12'hFF0: e.q = 32'(m_led);
        12'hFF1: e.q = 32'(m_pend);
        12'hFF2: e.q = m_tbase + 32'(m_tk / CLKS);
        12'hFF3: e.q = m_lfsr;
        12'hFF4: e.q = 32'(m_score);
        default: e.q = '0;
      endcase
    end
    // A raw rise is seen as a pending set two edges after it is first sampled.
    rise = raw_hist[1] & ~raw_hist[2];
    raw_hist[2] = raw_hist[1];
    raw_hist[1] = raw_hist[0];
    raw_hist[0] = btn;
    if (we && a == 12'hFF1) m_pend = (m_pend & ~d[NM-1:0]) | rise;
    else m_pend = m_pend | rise;
    if (we && a == 12'hFF2) begin
      m_tbase = d;
      m_tk    = 0;
    end else begin
      m_tk++;
    end
    if (we && a == 12'hFF3) m_lfsr = (d == 0) ? 32'd1 : d;
    else m_lfsr = lfsr_step(m_lfsr);
    if (we && a == 12'hFF0) m_led = d[NM-1:0];
    if (we && a == 12'hFF4) m_score = d[15:0];
    if (we && a < 12'd1024) mem[int'(a)] = d;
    e.leds  = m_led;
    e.score = m_score;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.do_q) chk($sformatf("q_dmem@%h", e.addr), q_dmem, e.q);
        chk("leds", 32'(leds), 32'(e.leds));
        chk("score_out", 32'(score_out), 32'(e.score));
      end
    end
  end

  initial begin : stim
    logic [NM-1:0] btn;
    logic [11:0]   a;
    int            r;
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    address_dmem = '0;
    d_dmem       = '0;
    wren_dmem    = 1'b0;
    buttons_raw  = '0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    chk("reset q_dmem", q_dmem, 32'd0);
    chk("reset leds", 32'(leds), 32'd0);
    chk("reset score", 32'(score_out), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) cycle(12'hFF0 + 12'(i), 1'b0, '0, '0);

    cycle(12'd5, 1'b1, 32'hDEAD_BEEF, '0);
    cycle(12'd5, 1'b0, '0, '0);
    cycle(12'd5, 1'b1, 32'h1, '0);
    cycle(12'd5, 1'b0, '0, '0);
    cycle(12'd5, 1'b1, 32'hDEAD_BEEF, '0);

    cycle(12'hFF0, 1'b1, 32'h1FF, '0);
    cycle(12'hFF4, 1'b1, 32'h12345, '0);
    cycle(12'hFF4, 1'b0, '0, '0);
    cycle(12'h800, 1'b0, '0, '0);
    cycle(12'hFF0, 1'b0, '0, '0);

    for (int i = 0; i < 10; i++) cycle(12'hFF1, 1'b0, '0, 9'h008);
    for (int i = 0; i < 4; i++) cycle(12'hFF1, 1'b0, '0, '0);
    cycle(12'hFF1, 1'b0, '0, 9'h008);
    cycle(12'hFF1, 1'b0, '0, 9'h008);
    cycle(12'hFF1, 1'b1, 32'h008, 9'h008);
    cycle(12'hFF1, 1'b0, '0, 9'h008);
    cycle(12'hFF1, 1'b1, 32'h008, 9'h008);
    for (int i = 0; i < 3; i++) cycle(12'hFF1, 1'b0, '0, '0);

    cycle(12'hFF2, 1'b1, 32'hFFFF_FFFF, '0);
    for (int i = 0; i < 7; i++) cycle(12'hFF2, 1'b0, '0, '0);

    cycle(12'hFF3, 1'b1, 32'h0, '0);
    cycle(12'hFF3, 1'b0, '0, '0);
    cycle(12'hFF3, 1'b0, '0, '0);
    cycle(12'hFF3, 1'b0, '0, '0);

    cycle(12'hFF2, 1'b1, 32'h55, 9'h021);
    for (int i = 0; i < 4; i++) cycle(12'hFF1, 1'b0, '0, 9'h021);
    cycle(12'hFF1, 1'b0, '0, '0);

    // Asynchronous reset mid-run, with a read of LED in flight.
    address_dmem = 12'hFF0;
    wren_dmem    = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("midrst q_dmem", q_dmem, 32'd0);
    chk("midrst leds", 32'(leds), 32'd0);
    chk("midrst score", 32'(score_out), 32'd0);
    @(posedge clock);
    #1;
    chk("midrst q_dmem held", q_dmem, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) cycle(12'hFF0 + 12'(i), 1'b0, '0, '0);
    cycle(12'd5, 1'b0, '0, '0);

    btn = '0;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      a = 12'($urandom_range(0, 15));
      else if (r < 9) a = 12'hFF0 + 12'(r - 4);
      else begin
        case ($urandom_range(0, 3))
          0:       a = 12'h800;
          1:       a = 12'hFFF;
          2:       a = 12'h400;
          default: a = 12'hFF5;
        endcase
      end
      if ($urandom_range(0, 3) == 0) btn = NM'($urandom);
      cycle(a, ($urandom_range(0, 2) == 0), $urandom, btn);
    end

    @(posedge clock);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
